bcd_display_ctrl: RTL and testbench

Sequential controller for the lab's 4-digit multiplexed seven-segment display. On a load request it captures a 14-bit binary value, converts it to four BCD digits with a serial shift-add-3 (double-dabble) datapath over 14 cycles, and commits the result to a display register. It continuously time-multiplexes the committed digits onto shared segment lines. It sits between the counting/arithmetic logic that produces `value` and the board's anode/segment pins.

---
 rtl/bcd_display_pkg.sv | 43 ++++
 rtl/bcd_seg7.sv | 29 ++
 rtl/bcd_display_ctrl.sv | 145 ++++++++++++++
 tb/tb_bcd_display_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_pkg.sv
// Shared constants, FSM state type and seven-segment patterns for the BCD display controller.
package bcd_display_pkg;

   localparam int unsigned BIN_W   = 14;
   localparam int unsigned DIGITS  = 4;
   localparam int unsigned BCD_MAX = 9999;
   localparam int unsigned BCD_W   = 4 * DIGITS;
   localparam int unsigned ACC_W   = BCD_W + BIN_W;

   localparam logic [BIN_W-1:0] BCD_MAX_V = BIN_W'(BCD_MAX);

   typedef enum logic [1:0] {
      StIdle,
      StConvert,
      StUpdate
   } state_e;

   // Active-low {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Double-dabble correction: nibbles >= 5 get +3 so the following shift carries into the next digit.
   function automatic logic [BCD_W-1:0] add3_adjust(input logic [BCD_W-1:0] bcd);
      logic [BCD_W-1:0] res;
      res = bcd;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bcd_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder with a blank override.
module bcd_seg7
   import bcd_display_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD conversion (serial double-dabble) plus 4-digit multiplexed seven-segment scan.
// Optional leading-zero blanking is enabled by defining BCD_DISPLAY_BLANK_EN.
module bcd_display_ctrl
   import bcd_display_pkg::*;
#(
   parameter int unsigned CLK_DIV = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [BIN_W-1:0] value,
   output logic             busy,
   output logic             done,
   output logic             ovf,
   output logic [3:0]       an,
   output logic [6:0]       seg
);

   localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [3:0]       iter_q, iter_d;
   logic             ovf_q, ovf_d;
   logic [BCD_W-1:0] disp_q, disp_d;
   logic [BIN_W-1:0] clamped;

   logic [CntW-1:0]  div_q, div_d;
   logic [1:0]       idx_q, idx_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_next;
   logic [3:0]       digit_sel;
   logic             blank_sel;
   logic             tick;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:    if (load) state_d = StConvert;
         StConvert: if (iter_q == 4'd1) state_d = StUpdate;
         StUpdate:  state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      busy = (state_q == StConvert) || (state_q == StUpdate);
      done = (state_q == StUpdate);
   end

   // ---------------- Conversion datapath ----------------
   assign clamped = (value > BCD_MAX_V) ? BCD_MAX_V : value;

   always_comb begin
      acc_d  = acc_q;
      iter_d = iter_q;
      ovf_d  = ovf_q;
      disp_d = disp_q;
      case (state_q)
         StIdle: begin
            if (load) begin
               acc_d  = {{BCD_W{1'b0}}, clamped};
               iter_d = 4'(BIN_W);
               ovf_d  = (value > BCD_MAX_V);
            end
         end
         StConvert: begin
            acc_d  = {add3_adjust(acc_q[ACC_W-1 -: BCD_W]), acc_q[BIN_W-1:0]} << 1;
            iter_d = iter_q - 4'd1;
         end
         StUpdate: disp_d = acc_q[ACC_W-1 -: BCD_W];
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q  <= '0;
         iter_q <= '0;
         ovf_q  <= 1'b0;
         disp_q <= '0;
      end else begin
         acc_q  <= acc_d;
         iter_q <= iter_d;
         ovf_q  <= ovf_d;
         disp_q <= disp_d;
      end
   end

   // ---------------- Scan ----------------
   assign tick  = (div_q == CntW'(CLK_DIV - 1));
   assign div_d = tick ? '0 : div_q + 1'b1;
   assign idx_d = tick ? idx_q + 2'd1 : idx_q;
   assign an_d  = ~(4'b0001 << idx_d);

   // Next index drives the mux so an and seg switch together on the same edge.
   assign digit_sel = disp_q[{idx_d, 2'b00} +: 4];

`ifdef BCD_DISPLAY_BLANK_EN
   logic [3:0] lead_zero;
   always_comb begin
      lead_zero[3] = (disp_q[15:12] == 4'd0);
      lead_zero[2] = lead_zero[3] && (disp_q[11:8] == 4'd0);
      lead_zero[1] = lead_zero[2] && (disp_q[7:4] == 4'd0);
      lead_zero[0] = 1'b0;
      blank_sel    = lead_zero[idx_d];
   end
`else
   assign blank_sel = 1'b0;
`endif

   bcd_seg7 u_seg7 (
      .digit (digit_sel),
      .blank (blank_sel),
      .seg   (seg_next)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q <= '0;
         idx_q <= 2'd0;
         an_q  <= 4'b1110;
         seg_q <= SEG_0;
      end else begin
         div_q <= div_d;
         idx_q <= idx_d;
         an_q  <= an_d;
         seg_q <= seg_next;
      end
   end

   assign ovf = ovf_q;
   assign an  = an_q;
   assign seg = seg_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Self-checking bench for bcd_display_ctrl: decimal reference model checked every cycle plus literal pins.
module tb_bcd_display_ctrl;

   localparam int D = 4;

   logic        clk;
   logic        rst;
   logic        load;
   logic [13:0] value;
   logic        busy;
   logic        done;
   logic        ovf;
   logic [3:0]  an;
   logic [6:0]  seg;

   int errors = 0;
   int checks = 0;
   bit chk_en = 0;

   bcd_display_ctrl #(.CLK_DIV(D)) dut (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .value (value),
      .busy  (busy),
      .done  (done),
      .ovf   (ovf),
      .an    (an),
      .seg   (seg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pow10(input int i);
      case (i)
         0: return 1;
         1: return 10;
         2: return 100;
         default: return 1000;
      endcase
   endfunction

   function automatic logic [6:0] pattern(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   // Decimal digit i of v, with optional leading-zero blanking.
   function automatic logic [6:0] exp_seg(input int v, input int i);
`ifdef BCD_DISPLAY_BLANK_EN
      if (i > 0 && v < pow10(i)) return 7'b1111111;
`endif
      return pattern((v / pow10(i)) % 10);
   endfunction

   function automatic logic [3:0] exp_an(input int i);
      case (i)
         0: return 4'b1110;
         1: return 4'b1101;
         2: return 4'b1011;
         default: return 4'b0111;
      endcase
   endfunction

   // Reference model: busy/done from cycles remaining, digits as plain decimal values.
   int m_left, m_pend, m_disp, m_shown, m_edges;
   bit m_ovf;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_left  <= 0;
         m_pend  <= 0;
         m_disp  <= 0;
         m_shown <= 0;
         m_edges <= 0;
         m_ovf   <= 0;
      end else begin
         m_edges <= m_edges + 1;
         m_shown <= m_disp;
         if (m_left == 0 && load) begin
            m_left <= 15;
            m_pend <= (int'(value) > 9999) ? 9999 : int'(value);
            m_ovf  <= (int'(value) > 9999);
         end else if (m_left > 0) begin
            m_left <= m_left - 1;
         end
         if (m_left == 1) m_disp <= m_pend;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", busy, m_left > 0);
         check("done", done, m_left == 1);
         check("ovf", ovf, m_ovf);
         check("an", an, exp_an((m_edges / D) % 4));
         check("seg", seg, exp_seg(m_shown, (m_edges / D) % 4));
      end
   end

   task automatic do_load(input int v);
      @(negedge clk);
      value = 14'(v);
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (done) seen = 1;
         else @(negedge clk);
      end
      if (!seen) check("done_timeout", 0, 1);
   endtask

   task automatic wait_an(input logic [3:0] target);
      bit seen;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (an == target) seen = 1;
         else @(negedge clk);
      end
      if (!seen) check("an_timeout", an, target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      int bcnt, done_at, dn;
      int vals[8] = '{0, 9, 10, 99, 100, 999, 1000, 9999};

      rst   = 1'b1;
      load  = 1'b0;
      value = '0;
      #1 rst = 1'b0;
      @(negedge clk);
      chk_en = 1;
      check("rst_an", an, 4'b1110);
      check("rst_seg", seg, 7'b1000000);
      check("rst_busy", busy, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      // 1234: busy length, done position, scan order
      do_load(1234);
      bcnt    = 0;
      done_at = -1;
      for (int c = 1; c <= 30; c++) begin
         if (busy) bcnt++;
         if (done && done_at < 0) done_at = c;
         @(negedge clk);
      end
      check("busy_len", bcnt, 15);
      check("done_cycle", done_at, 15);
      wait_an(4'b0111);
      wait_an(4'b1110);
      check("scan0_seg", seg, 7'b0011001);
      repeat (D) @(negedge clk);
      check("scan1_an", an, 4'b1101);
      check("scan1_seg", seg, 7'b0110000);
      repeat (D) @(negedge clk);
      check("scan2_an", an, 4'b1011);
      check("scan2_seg", seg, 7'b0100100);
      repeat (D) @(negedge clk);
      check("scan3_an", an, 4'b0111);
      check("scan3_seg", seg, 7'b1111001);

      // Overflow clamps to 9999, then a small value clears ovf
      do_load(16383);
      wait_done();
      repeat (3) @(negedge clk);
      check("ovf_set", ovf, 1'b1);
      repeat (20) @(negedge clk);
      do_load(7);
      wait_done();
      repeat (3) @(negedge clk);
      check("ovf_clr", ovf, 1'b0);
      wait_an(4'b0111);
`ifdef BCD_DISPLAY_BLANK_EN
      check("thousands_7", seg, 7'b1111111);
`else
      check("thousands_7", seg, 7'b1000000);
`endif
      repeat (20) @(negedge clk);

      // load held high: starts every 16 cycles, no extra done
      @(negedge clk);
      value = 14'd500;
      load  = 1'b1;
      dn    = 0;
      for (int c = 0; c < 48; c++) begin
         @(negedge clk);
         if (done) dn++;
      end
      load = 1'b0;
      check("held_done_cnt", dn, 3);
      repeat (20) @(negedge clk);

      // value changed mid-conversion is ignored
      @(negedge clk);
      value = 14'd555;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
      value = 14'd999;
      wait_done();
      repeat (3) @(negedge clk);
      wait_an(4'b1101);
      check("mid_change_tens", seg, 7'b0010010);
      repeat (20) @(negedge clk);

      // reset during conversion of 9876
      do_load(9876);
      repeat (6) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_an", an, 4'b1110);
      check("abort_seg", seg, 7'b1000000);
      @(negedge clk);
      #2 rst = 1'b1;
      dn = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (done) dn++;
      end
      check("abort_no_done", dn, 0);

      // decimal boundary values, checked by the model across a full scan
      foreach (vals[i]) begin
         do_load(vals[i]);
         wait_done();
         repeat (20) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
